// File: rtl/flow_stack.sv
// flow_stack: bounded call stack plus per-lane enable-mask stacks with overflow/underflow trap
module flow_stack #(
  parameter int WIDTH  = 16,
  parameter int CDEPTH = 4,
  parameter int EDEPTH = 32,
  parameter int LANES  = 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            op_valid,
  input  logic [2:0]                      op,
  input  logic [WIDTH-1:0]                op_pc,
  input  logic [LANES-1:0]                cond,
  input  logic                            err_clr,
  output logic                            op_ready,
  output logic                            resp_valid,
  output logic                            take,
  output logic [WIDTH-1:0]                ret_pc,
  output logic [LANES-1:0]                en,
  output logic                            any_en,
  output logic [$clog2(CDEPTH+1)-1:0]     depth,
  output logic                            ovf,
  output logic                            unf
);
  localparam int DW = $clog2(CDEPTH+1);
  localparam int AW = CDEPTH > 1 ? $clog2(CDEPTH) : 1;
  typedef enum logic {RUN, ERR} state_t;
  state_t state;
  logic [EDEPTH-1:0] estk [LANES];
  logic [WIDTH-1:0] cstk [2**AW];
  logic acc, full, empty;
  assign op_ready = state == RUN;
  assign acc = op_valid & op_ready;
  assign full = depth == DW'(CDEPTH);
  assign empty = depth == '0;
  assign any_en = |en;
  // top-of-stack enable bit of each lane
  always_comb begin
    en = '0;
    for (int l = 0; l < LANES; l++) en[l] = estk[l][0];
  end
  // state, stacks and registered response
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      resp_valid <= 1'b0;
      take <= 1'b0;
      ret_pc <= '0;
      depth <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
      for (int l = 0; l < LANES; l++) estk[l] <= '1;
    end else begin
      resp_valid <= acc;
      if (state == ERR && err_clr) begin
        state <= RUN;
        ovf <= 1'b0;
        unf <= 1'b0;
      end
      if (acc) begin
        take <= 1'b0;
        case (op)
          3'd1: if (any_en) begin
            if (full) begin
              ovf <= 1'b1;
              state <= ERR;
            end else begin
              cstk[AW'(depth)] <= op_pc;
              depth <= depth + DW'(1);
              take <= 1'b1;
            end
          end
          3'd2: if (any_en) begin
            if (empty) begin
              unf <= 1'b1;
              state <= ERR;
            end else begin
              ret_pc <= cstk[AW'(depth - DW'(1))] + WIDTH'(1);
              depth <= depth - DW'(1);
              take <= 1'b1;
            end
          end
          3'd3: for (int l = 0; l < LANES; l++) estk[l] <= {estk[l][EDEPTH-2:0], estk[l][0]};
          3'd4: for (int l = 0; l < LANES; l++) estk[l] <= {1'b1, estk[l][EDEPTH-1:1]};
          3'd5: for (int l = 0; l < LANES; l++) estk[l][0] <= 1'b1;
          3'd6: begin
            for (int l = 0; l < LANES; l++) estk[l][0] <= estk[l][0] & cond[l];
            take <= ~|(en & cond);
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_flow_stack.sv
// tb_flow_stack: table vectors, corner sequences and random ops against a queue-based model
module tb_flow_stack;
  localparam int W = 16, CD = 4, ED = 2, L = 4;
  logic clk = 0, reset = 1, op_valid = 0, err_clr = 0;
  logic [2:0] op = 0;
  logic [W-1:0] op_pc = 0;
  logic [L-1:0] cond = 0;
  logic op_ready, resp_valid, take, any_en, ovf, unf;
  logic [W-1:0] ret_pc;
  logic [L-1:0] en;
  logic [2:0] depth;
  int tests = 0, fails = 0;
  logic [W-1:0] cq [$];
  logic eq [L][$];
  logic merr, movf, munf, mrv, mtake;
  logic [W-1:0] mret;

  typedef struct packed {
    logic v; logic [2:0] op; logic [15:0] pc; logic [3:0] c;
    logic rv; logic tk; logic [15:0] rp; logic [3:0] en; logic [2:0] dp;
  } vec_t;
  vec_t tbl [13];

  flow_stack #(.WIDTH(W), .CDEPTH(CD), .EDEPTH(ED), .LANES(L)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op(op), .op_pc(op_pc), .cond(cond),
    .err_clr(err_clr), .op_ready(op_ready), .resp_valid(resp_valid), .take(take),
    .ret_pc(ret_pc), .en(en), .any_en(any_en), .depth(depth), .ovf(ovf), .unf(unf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] g, input logic [31:0] e);
    tests++;
    if (g !== e) begin
      fails++;
      $display("FAIL %s got %0h expected %0h", n, g, e);
    end
  endtask

  function automatic logic [L-1:0] men();
    logic [L-1:0] r;
    for (int l = 0; l < L; l++) r[l] = eq[l][0];
    return r;
  endfunction

  task automatic mreset();
    cq.delete();
    for (int l = 0; l < L; l++) begin
      eq[l].delete();
      repeat (ED) eq[l].push_back(1'b1);
    end
    merr = 0; movf = 0; munf = 0; mrv = 0; mtake = 0; mret = 0;
  endtask

  task automatic mstep(input logic v, input logic [2:0] o, input logic [W-1:0] pc,
                       input logic [L-1:0] c, input logic clr);
    logic acc, a;
    acc = v && !merr;
    a = |men();
    mrv = acc;
    if (merr && clr) begin merr = 0; movf = 0; munf = 0; end
    if (acc) begin
      mtake = 0;
      if (o == 1 && a) begin
        if (cq.size() == CD) begin movf = 1; merr = 1; end
        else begin cq.push_back(pc); mtake = 1; end
      end else if (o == 2 && a) begin
        if (cq.size() == 0) begin munf = 1; merr = 1; end
        else begin mret = cq.pop_back() + 16'd1; mtake = 1; end
      end else if (o == 3) begin
        for (int l = 0; l < L; l++) begin eq[l].push_front(eq[l][0]); void'(eq[l].pop_back()); end
      end else if (o == 4) begin
        for (int l = 0; l < L; l++) begin void'(eq[l].pop_front()); eq[l].push_back(1'b1); end
      end else if (o == 5) begin
        for (int l = 0; l < L; l++) eq[l][0] = 1'b1;
      end else if (o == 6) begin
        for (int l = 0; l < L; l++) eq[l][0] = eq[l][0] & c[l];
        mtake = men() == '0;
      end
    end
  endtask

  task automatic cmp(input string n);
    chk({n, "_rdy"}, 32'(op_ready), 32'(!merr));
    chk({n, "_rv"}, 32'(resp_valid), 32'(mrv));
    if (mrv) chk({n, "_take"}, 32'(take), 32'(mtake));
    chk({n, "_retpc"}, 32'(ret_pc), 32'(mret));
    chk({n, "_en"}, 32'(en), 32'(men()));
    chk({n, "_anyen"}, 32'(any_en), 32'(|men()));
    chk({n, "_depth"}, 32'(depth), cq.size());
    chk({n, "_ovf"}, 32'(ovf), 32'(movf));
    chk({n, "_unf"}, 32'(unf), 32'(munf));
  endtask

  task automatic step(input string n, input logic v, input logic [2:0] o, input logic [W-1:0] pc,
                      input logic [L-1:0] c, input logic clr);
    op_valid = v; op = o; op_pc = pc; cond = c; err_clr = clr;
    mstep(v, o, pc, c, clr);
    @(posedge clk);
    #1;
    cmp(n);
  endtask

  task automatic do_reset();
    reset = 1; op_valid = 1; op = 1; op_pc = 16'h1234; err_clr = 1;
    @(posedge clk);
    mreset();
    #1;
    cmp("reset");
    chk("reset_rv", 32'(resp_valid), 0);
    chk("reset_en", 32'(en), 32'hf);
    chk("reset_rdy", 32'(op_ready), 1);
    reset = 0; op_valid = 0; err_clr = 0;
  endtask

  initial begin
    tbl[0]  = '{1, 3'd1, 16'h0010, 4'h0, 1, 1, 16'h0000, 4'hf, 3'd1};
    tbl[1]  = '{1, 3'd2, 16'h0000, 4'h0, 1, 1, 16'h0011, 4'hf, 3'd0};
    tbl[2]  = '{1, 3'd3, 16'h0000, 4'h0, 1, 0, 16'h0011, 4'hf, 3'd0};
    tbl[3]  = '{1, 3'd6, 16'h0000, 4'h5, 1, 0, 16'h0011, 4'h5, 3'd0};
    tbl[4]  = '{1, 3'd6, 16'h0000, 4'h0, 1, 1, 16'h0011, 4'h0, 3'd0};
    tbl[5]  = '{1, 3'd1, 16'h0020, 4'h0, 1, 0, 16'h0011, 4'h0, 3'd0};
    tbl[6]  = '{1, 3'd4, 16'h0000, 4'h0, 1, 0, 16'h0011, 4'hf, 3'd0};
    tbl[7]  = '{1, 3'd5, 16'h0000, 4'h0, 1, 0, 16'h0011, 4'hf, 3'd0};
    tbl[8]  = '{1, 3'd0, 16'h0000, 4'h0, 1, 0, 16'h0011, 4'hf, 3'd0};
    tbl[9]  = '{0, 3'd1, 16'h0030, 4'h0, 0, 0, 16'h0011, 4'hf, 3'd0};
    tbl[10] = '{1, 3'd1, 16'hffff, 4'h0, 1, 1, 16'h0011, 4'hf, 3'd1};
    tbl[11] = '{1, 3'd2, 16'h0000, 4'h0, 1, 1, 16'h0000, 4'hf, 3'd0};
    tbl[12] = '{1, 3'd7, 16'h0040, 4'h0, 1, 0, 16'h0000, 4'hf, 3'd0};
    do_reset();
    for (int i = 0; i < 13; i++) begin
      step("tbl", tbl[i].v, tbl[i].op, tbl[i].pc, tbl[i].c, 0);
      chk($sformatf("tbl%0d_rv", i), 32'(resp_valid), 32'(tbl[i].rv));
      if (tbl[i].rv) chk($sformatf("tbl%0d_take", i), 32'(take), 32'(tbl[i].tk));
      chk($sformatf("tbl%0d_retpc", i), 32'(ret_pc), 32'(tbl[i].rp));
      chk($sformatf("tbl%0d_en", i), 32'(en), 32'(tbl[i].en));
      chk($sformatf("tbl%0d_depth", i), 32'(depth), 32'(tbl[i].dp));
    end
    for (int i = 1; i <= 5; i++) step("ovf_call", 1, 3'd1, 16'(i), 0, 0);
    chk("ovf_take", 32'(take), 0);
    chk("ovf_flag", 32'(ovf), 1);
    step("ovf_ignored", 1, 3'd2, 0, 0, 0);
    chk("ovf_ignored_rv", 32'(resp_valid), 0);
    chk("ovf_ignored_depth", 32'(depth), 4);
    step("ovf_clr", 0, 3'd0, 0, 0, 1);
    chk("ovf_clr_rdy", 32'(op_ready), 1);
    for (int i = 0; i < 4; i++) begin
      step("ovf_ret", 1, 3'd2, 0, 0, 0);
      chk("ovf_ret_pc", 32'(ret_pc), 32'(5 - i));
    end
    chk("ovf_ret_depth", 32'(depth), 0);
    step("unf_ret", 1, 3'd2, 0, 0, 0);
    chk("unf_flag", 32'(unf), 1);
    chk("unf_rdy", 32'(op_ready), 0);
    step("unf_clr", 1, 3'd1, 16'h0077, 0, 1);
    chk("unf_clr_rv", 32'(resp_valid), 0);
    chk("unf_clr_depth", 32'(depth), 0);
    step("unf_next", 1, 3'd1, 16'h0078, 0, 0);
    chk("unf_next_depth", 32'(depth), 1);
    step("unf_pop", 1, 3'd2, 0, 0, 0);
    step("run_clr", 1, 3'd0, 0, 0, 1);
    step("ed_jf", 1, 3'd6, 0, 4'b1110, 0);
    chk("ed_jf_lane0", 32'(en[0]), 0);
    for (int i = 0; i < 3; i++) step("ed_push", 1, 3'd3, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step("ed_pop", 1, 3'd4, 0, 0, 0);
      chk($sformatf("ed_pop%0d_lane0", i), 32'(en[0]), 32'(i != 0));
    end
    step("err_enter", 1, 3'd2, 0, 0, 0);
    chk("err_enter_rdy", 32'(op_ready), 0);
    do_reset();
    step("inflight_call", 1, 3'd1, 16'h0abc, 0, 0);
    do_reset();
    chk("inflight_depth", 32'(depth), 0);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      else step("rnd", $urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 16'($urandom),
                4'($urandom | ($urandom_range(0, 1) ? 4'hf : 4'h0)), $urandom_range(0, 3) == 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
